// File: rtl/L1_cache_pkg.sv
// L1 icache shared definitions: line geometry, NOP filler, fill FSM states
// and the icache <-> memory request/response payloads.
package L1_cache_pkg;

   localparam int unsigned LINE_WORDS = 8;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
   localparam int unsigned CNT_W      = $clog2(LINE_WORDS);
   localparam int unsigned OFFS_W     = $clog2(LINE_W / 8);
   localparam int unsigned TAG_W      = 32 - OFFS_W;

   // RISC-V "addi x0,x0,0", used to fill words whose read timed out
   localparam logic [WORD_W-1:0] NOP_INSN = 32'h0000_0013;

   // Element LINE_WORDS-1 (MSBs) holds word 0 of the line
   typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

   typedef enum logic [2:0] {
      FILL_IDLE,
      FILL_REQ,
      FILL_WAIT,
      FILL_RESP,
      FILL_DRAIN
   } fill_state_e;

   typedef struct packed {
      logic        m_strobe;
      logic [31:0] m_addr;
   } icache_mem_req_t;

   typedef struct packed {
      logic              m_ready;
      logic [LINE_W-1:0] m_dout;
   } icache_mem_resp_t;

endpackage

// File: rtl/icache_fill_linebuf.sv
// Single-entry line buffer holding the most recently filled line.
// Ports: flush_i clears valid (wins over a same-cycle fill); fill_i captures
// fill_tag_i/fill_line_i; hit_o_c is a combinational tag match against
// lookup_tag_i; line_o is the buffered line.
module icache_fill_linebuf
   import L1_cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             fill_i,
   input  logic [TAG_W-1:0] fill_tag_i,
   input  line_t            fill_line_i,
   input  logic [TAG_W-1:0] lookup_tag_i,
   output logic             hit_o_c,
   output line_t            line_o
);

   logic             valid_q, valid_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   line_t            line_q, line_d;

   // Capture on fill; flush has the last word on valid
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      line_d  = line_q;
      if (fill_i) begin
         valid_d = 1'b1;
         tag_d   = fill_tag_i;
         line_d  = fill_line_i;
      end
      if (flush_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         line_q  <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         line_q  <= line_d;
      end
   end

   assign hit_o_c = valid_q && !flush_i && (tag_q == lookup_tag_i);
   assign line_o  = line_q;

endmodule

// File: rtl/icache_fill_responder.sv
// Memory-side responder for L1 icache line fills: reads the 8 words of the
// requested line over a 32-bit word port, one outstanding read at a time,
// and returns the packed line with a one-cycle m_ready pulse.
// Ports: icache_req/mem_resp to the icache; rd_valid/rd_ready/rd_addr and
// rd_resp_valid/rd_resp_data to the backing port; flush for the line
// buffer; busy (not IDLE); timeout_err (sticky, cleared by rst).
// Optional line buffer: define ICACHE_FILL_LINEBUF_EN.
module icache_fill_responder
   import L1_cache_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  icache_mem_req_t  icache_req,
   output icache_mem_resp_t mem_resp,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [31:0]      rd_addr,
   input  logic             rd_resp_valid,
   input  logic [31:0]      rd_resp_data,
   input  logic             flush,
   output logic             busy,
   output logic             timeout_err
);

   localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

   fill_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TAG_W-1:0]  line_addr_q, line_addr_d;
   line_t             line_q, line_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              rd_valid_q, rd_valid_d;
   logic [31:0]       rd_addr_q, rd_addr_d;
   logic              m_ready_q, m_ready_d;
   line_t             m_dout_q, m_dout_d;
   logic              busy_q, busy_d;
   logic              timeout_err_q, timeout_err_d;

   logic              expire_c, word_done_c, fill_done_c, hit_c;
   logic [TAG_W-1:0]  req_tag_c;
   line_t             buf_line;

   assign req_tag_c = icache_req.m_addr[31:OFFS_W];

   // Timeout fires on the MAX_WAIT-th silent WAIT cycle; a response that
   // same cycle takes priority
   assign expire_c    = (MAX_WAIT != 0) && (state_q == FILL_WAIT) && !rd_resp_valid
                        && (wait_q == WAIT_W'(MAX_WAIT - 1));
   assign word_done_c = (state_q == FILL_WAIT) && (rd_resp_valid || expire_c);
   assign fill_done_c = word_done_c && (cnt_q == LAST_WORD);

`ifdef ICACHE_FILL_LINEBUF_EN
   icache_fill_linebuf u_linebuf (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .fill_i       (fill_done_c),
      .fill_tag_i   (line_addr_q),
      .fill_line_i  (line_d),
      .lookup_tag_i (req_tag_c),
      .hit_o_c      (hit_c),
      .line_o       (buf_line)
   );
   logic unused_offs;
   assign unused_offs = ^icache_req.m_addr[OFFS_W-1:0];
`else
   assign hit_c    = 1'b0;
   assign buf_line = '0;
   logic unused_inputs;
   assign unused_inputs = ^{flush, fill_done_c, icache_req.m_addr[OFFS_W-1:0]};
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL_IDLE:  if (icache_req.m_strobe) state_d = hit_c ? FILL_RESP : FILL_REQ;
         FILL_REQ:   if (rd_ready) state_d = FILL_WAIT;
         FILL_WAIT:  if (word_done_c) state_d = (cnt_q == LAST_WORD) ? FILL_RESP : FILL_REQ;
         FILL_RESP:  state_d = FILL_DRAIN;
         FILL_DRAIN: if (!icache_req.m_strobe) state_d = FILL_IDLE;
         default:    state_d = FILL_IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      cnt_d         = cnt_q;
      line_addr_d   = line_addr_q;
      line_d        = line_q;
      wait_d        = '0;
      timeout_err_d = timeout_err_q | expire_c;
      case (state_q)
         FILL_IDLE: begin
            if (icache_req.m_strobe) begin
               line_addr_d = req_tag_c;
               cnt_d       = '0;
               if (hit_c) line_d = buf_line;
            end
         end
         FILL_WAIT: begin
            if (word_done_c) begin
               line_d[LAST_WORD - cnt_q] = rd_resp_valid ? rd_resp_data : NOP_INSN;
               if (cnt_q != LAST_WORD) cnt_d = cnt_q + CNT_W'(1);
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: ;
      endcase
      rd_valid_d = (state_d == FILL_REQ);
      rd_addr_d  = rd_valid_d ? {line_addr_d, cnt_d, 2'b00} : '0;
      m_ready_d  = (state_d == FILL_RESP);
      m_dout_d   = m_ready_d ? line_d : '0;
      busy_d     = (state_d != FILL_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q         <= '0;
         line_addr_q   <= '0;
         line_q        <= '0;
         wait_q        <= '0;
         rd_valid_q    <= 1'b0;
         rd_addr_q     <= '0;
         m_ready_q     <= 1'b0;
         m_dout_q      <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         line_addr_q   <= line_addr_d;
         line_q        <= line_d;
         wait_q        <= wait_d;
         rd_valid_q    <= rd_valid_d;
         rd_addr_q     <= rd_addr_d;
         m_ready_q     <= m_ready_d;
         m_dout_q      <= m_dout_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign mem_resp.m_ready = m_ready_q;
   assign mem_resp.m_dout  = m_dout_q;
   assign rd_valid         = rd_valid_q;
   assign rd_addr          = rd_addr_q;
   assign busy             = busy_q;
   assign timeout_err      = timeout_err_q;

endmodule

// File: doc/icache_fill_responder.md
Name: icache_fill_responder

Overview:
- Memory-side responder for L1 icache line-fill requests. Accepts an icache_mem_req_t (m_strobe, m_addr) and returns an icache_mem_resp_t (m_ready pulse, 256-bit m_dout).
- Fetches the 8 words of the requested line one at a time over a 32-bit word-read port to backing memory/bus, then packs them into a line.
- Sits between the L1 icache and the memory/bus arbiter.

Parameters:
- LINE_WORDS, 8, words per line. Fixed for the current icache; the line is LINE_WORDS*32 bits.
- MAX_WAIT, 255, cycles with no rd_resp_valid before the error path triggers; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- icache_req  in  icache_mem_req_t  m_strobe (held high until m_ready), m_addr (byte address)
- mem_resp  out  icache_mem_resp_t  m_ready (1-cycle pulse), m_dout[255:0]
- rd_valid  out  1  word-read request valid
- rd_ready  in  1  backing port accepts the request
- rd_addr  out  32  word byte-address, 4-byte aligned
- rd_resp_valid  in  1  read data returned
- rd_resp_data  in  32  read data
- flush  in  1  invalidate the line buffer (only when the optional feature is present)
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky; set on a MAX_WAIT expiry, cleared only by rst

Behaviour:
- Reset (async, any state, including mid-fill):
  - state=IDLE, word counter=0.
  - rd_valid=0, m_ready=0, m_dout=0, busy=0, timeout_err=0.
  - A pending backing response arriving after reset is ignored.
- States: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE:
  - m_strobe=1 -> latch line_addr = m_addr[31:5]; low 5 bits are ignored.
  - Clear the counter and go to REQ.
- REQ:
  - rd_valid=1, rd_addr={line_addr, cnt[2:0], 2'b00}.
  - Hold rd_valid and rd_addr stable until rd_ready; on the rd_valid&&rd_ready cycle go to WAIT.
- WAIT:
  - On rd_resp_valid, write rd_resp_data into line word cnt. Word 0 goes to m_dout[255:224]; word k goes to bits [255-32k : 224-32k].
  - If cnt==7 go to RESP, else cnt+1 and go to REQ.
  - Exactly one outstanding read at a time.
- RESP:
  - m_ready=1 for exactly one cycle, with m_dout = the assembled line.
  - m_dout is 0 in every other cycle.
  - Next state is DRAIN.
- DRAIN:
  - Wait for m_strobe==0, then go to IDLE.
  - This prevents a stale, still-high strobe being re-accepted as a new request.
- Latency (no line buffer, rd_ready=1, response 1 cycle after accept): strobe seen at cycle 0 -> m_ready at cycle 17.
- m_addr changes after the IDLE latch are ignored.
- Timeout:
  - In WAIT, a counter runs while rd_resp_valid=0.
  - Reaching MAX_WAIT sets timeout_err, writes 32'h0000_0013 (NOP) into the current word, and advances as if data had arrived. The icache therefore never hangs.
- A response arriving in the same cycle as the timeout expiry takes priority; timeout_err is not set.
- rd_resp_valid outside WAIT is ignored.

Optional Feature:
- Macro: ICACHE_FILL_LINEBUF_EN.
- Defined:
  - Keep the last filled line plus its line_addr and a valid bit.
  - In IDLE, a strobe whose m_addr[31:5] equals the buffered tag while valid=1 goes straight to RESP: m_ready one cycle after the strobe is seen, and no rd_valid activity.
  - flush=1 clears valid in the same cycle. If flush coincides with a fill completing, flush wins and valid ends at 0.
  - rst clears valid.
- Not defined:
  - No buffer; every request performs 8 backing reads. The flush input is present but ignored.

Decomposition:
- L1_cache_pkg: LINE_WORDS, the line width, the NOP constant, and the fill state typedef. icache_mem_req_t and icache_mem_resp_t remain where they are already defined.
- One sub-module: icache_fill_linebuf, holding the tag/valid/line register and the compare logic. It is instantiated only under ICACHE_FILL_LINEBUF_EN.

Test Plan:
- Basic fill:
  - Stimulus: m_addr=32'h0000_1234, backing returns word i = 32'hA000_0000+i, rd_ready=1, 1-cycle response.
  - Required: rd_addr sequence 0x1220..0x123C; m_ready single pulse at cycle 17; m_dout[255:224]=A0000000, m_dout[31:0]=A0000007.
- Backpressure:
  - Stimulus: rd_ready low for 3 cycles on word 2.
  - Required: rd_valid and rd_addr=0x...28 held stable for those cycles; m_ready delayed by 3 cycles; data unchanged.
- Strobe hold and re-request:
  - Stimulus: m_strobe stays high 2 cycles past m_ready, then a new request to 0x2000.
  - Required: no second fill until the strobe drops; the new fill starts with rd_addr=0x2000.
- Reset mid-fill:
  - Stimulus: assert rst while in WAIT on word 4, with a late rd_resp_valid after rst.
  - Required: outputs go to zero immediately; the late response is ignored; the next fill is correct.
- Timeout (MAX_WAIT=4):
  - Stimulus: word 5 never responds.
  - Required: timeout_err=1; m_dout word 5 = 32'h00000013; m_ready still pulses.
- ICACHE_FILL_LINEBUF_EN:
  - Stimulus: two back-to-back requests to 0x1234, then flush, then a third request to 0x1234.
  - Required: the second request gives m_ready 1 cycle after the strobe with no rd_valid activity; the third performs 8 backing reads.
